// File: rtl/delay_pkg.sv
// Shared constants and helpers for the delay pipeline.
package delay_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 2;

  // Bits needed to hold an occupancy count from 0 to n inclusive.
  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One pipeline slot: valid bit plus payload register with elastic handshake.
module delay_stage
  import delay_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             next_rdy,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             rdy
);

  // An empty slot, or one whose occupant moves on this cycle, can take a new word.
  assign rdy = !valid || next_rdy;

  // Slot update: reset clears everything, flush drops the word, otherwise load when ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (rdy) begin
      valid <= in_valid;
      if (in_valid) data <= in_data;
    end
  end

endmodule

// File: rtl/delay_pipe.sv
// Elastic delay line of STAGES slots with bubble collapse, flush and occupancy count.
module delay_pipe
  import delay_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [WIDTH-1:0]             i_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [WIDTH-1:0]             o_data,
  output logic [count_w(STAGES)-1:0]   o_count
);

  localparam int CW = count_w(STAGES);

  logic             v [STAGES];
  logic [WIDTH-1:0] d [STAGES];
  logic             xfer_in;
  logic             xfer_out;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             in_v;
    logic [WIDTH-1:0] in_d;
    logic             next_rdy;
    logic             stage_rdy;

    if (k == 0) begin : g_first
      assign in_v = i_valid;
      assign in_d = i_data;
    end else begin : g_next
      assign in_v = v[k-1];
      assign in_d = d[k-1];
    end

    if (k == STAGES - 1) begin : g_last
      assign next_rdy = i_ready;
    end else begin : g_mid
      assign next_rdy = g_stage[k+1].stage_rdy;
    end

    delay_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (i_clk),
      .rst      (i_rst),
      .flush    (i_flush),
      .in_valid (in_v),
      .in_data  (in_d),
      .next_rdy (next_rdy),
      .valid    (v[k]),
      .data     (d[k]),
      .rdy      (stage_rdy)
    );
  end

  // Reset forces ready high so the upstream sees a clean, accepting block.
  assign o_ready  = (g_stage[0].stage_rdy || i_rst) && !i_flush;
  assign o_valid  = v[STAGES-1];
  assign o_data   = d[STAGES-1];
  assign xfer_in  = i_valid && o_ready;
  assign xfer_out = o_valid && i_ready;

  // Occupancy tracks net transfers; reset and flush both empty the pipe.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      o_count <= '0;
    end else begin
      case ({xfer_in, xfer_out})
        2'b10:   o_count <= o_count + CW'(1);
        2'b01:   o_count <= o_count - CW'(1);
        default: o_count <= o_count;
      endcase
    end
  end

endmodule

// File: doc/delay_pipe.md
DELAY_PIPE -- requirements
Module: delay_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, legal range 1 or more.
REQ-002 Parameter STAGES, default 2: number of register stages, legal range 1 or more.
REQ-003 Port i_clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 Port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port i_flush, input, 1 bit: synchronous pipeline clear.
REQ-006 Port i_valid, input, 1 bit: upstream data valid.
REQ-007 Port o_ready, output, 1 bit: block can accept data this cycle.
REQ-008 Port i_data, input, WIDTH bits: upstream payload.
REQ-009 Port o_valid, output, 1 bit: downstream data valid; equals the valid bit of the last stage.
REQ-010 Port i_ready, input, 1 bit: downstream can accept.
REQ-011 Port o_data, output, WIDTH bits: downstream payload; equals the data of the last stage.
REQ-012 Port o_count, output, $clog2(STAGES+1) bits: number of occupied stages.

Function
REQ-013 Stages are numbered 0 (input side) to STAGES-1 (output side); each stage holds one valid bit and a WIDTH-bit data register.
REQ-014 Stage k ready: rdy[k] = !v[k] || rdy[k+1], with rdy[STAGES] = i_ready. This is a combinational chain, so bubbles collapse.
REQ-015 Stage k loads when rdy[k]; it takes v[k-1]/d[k-1], or i_valid/i_data for k=0. Data is captured only when the incoming valid is 1; otherwise the data register holds.
REQ-016 o_ready = rdy[0] && !i_flush.
REQ-017 Transfer rules: a transfer in occurs when i_valid && o_ready; a transfer out occurs when o_valid && i_ready.
REQ-018 Latency: with i_ready held at 1, a word accepted in cycle t appears on o_valid/o_data in cycle t+STAGES. Throughput is 1 word per cycle.
REQ-019 While o_valid=1 and i_ready=0, o_data holds stable and o_valid stays 1 (no drop, no change).
REQ-020 Words leave in acceptance order; no word is lost or duplicated except by flush.
REQ-021 Full: o_count = STAGES and i_ready = 0 gives o_ready = 0.
REQ-022 Full, with i_ready = 1 in the same cycle: o_ready = 1, and a simultaneous in/out transfer keeps o_count at STAGES.
REQ-023 Empty: o_count = 0 and o_valid = 0. An accepted word is not visible on the output in the same cycle.
REQ-024 o_count is registered and updated each cycle as +1 for a transfer in, -1 for a transfer out, net 0 for both. It always equals the popcount of v[].
REQ-025 i_flush = 1: all v[] and o_count are 0 in the next cycle. In the flush cycle no input is accepted (o_ready = 0), and a current output transfer still completes if i_ready = 1.
REQ-026 i_valid with i_flush is ignored. No illegal states exist, since every v/d combination is legal.

Reset
REQ-027 In a cycle with i_rst = 1, the next state is all v[] = 0, all d[] = 0, and o_count = 0. Resulting outputs are o_valid = 0, o_data = 0, o_count = 0.
REQ-028 Combinational during reset: o_ready = 1 after reset, and during reset when i_flush = 0. Transfers presented during reset are discarded.
REQ-029 Reset mid-operation discards all in-flight words. Reset has priority over i_flush and over loads.

Structure
REQ-030 Shared package delay_pkg holds:
- DEFAULT_WIDTH = 8
- DEFAULT_STAGES = 2
- a function returning the count width $clog2(N+1)
REQ-031 One sub-module, delay_stage, holds one stage's valid/data register, load enable and rdy output. delay_pipe instantiates STAGES of them in a generate loop and owns o_count.

Verification (bench configuration: WIDTH=8, STAGES=3 unless noted)
REQ-032 Streaming: push 0x01..0x0A back-to-back with i_ready=1 -> 0x01 appears 3 cycles after its acceptance, then one word per cycle in order, o_count steady at 3.
REQ-033 Backpressure: push 0x10..0x14 with i_ready=0 -> o_count reaches 3 and o_ready=0 with 0x10 held on o_data; release i_ready -> 0x10..0x14 delivered in order, none lost.
REQ-034 Bubble collapse: push 0xA0, 2 idle cycles, then 0xA1, with i_ready=0 -> o_count=2, and 0xA0 sits in stage 2 with 0xA1 in stage 1.
REQ-035 Flush: with 3 words resident and i_valid=1, data 0x55, assert i_flush -> next cycle o_valid=0 and o_count=0, and 0x55 never appears.
REQ-036 Reset mid-stream: assert i_rst while streaming -> next cycle o_valid=0, o_data=0, o_count=0; streaming resumes correctly after deassert.
REQ-037 Degenerate configuration: STAGES=1, WIDTH=1, random valid/ready -> the scoreboard matches and latency is 1 cycle.
